// File: rtl/conv_window_stream_pkg.sv
// Shared defaults and helpers for the KxK sliding-window generator.
package conv_window_stream_pkg;

    localparam int DEF_WIDTH  = 28;
    localparam int DEF_HEIGHT = 28;
    localparam int DEF_K      = 3;
    localparam int DEF_DATA_W = 1;
    localparam int DEF_CH     = 1;
    localparam int DEF_STRIDE = 1;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/conv_window_stream_line_buffer_ram.sv
// K-1 row banks of one frame line each, one shared column address.
// Asynchronous read so the window column can be assembled in the
// same cycle the new pixel overwrites the oldest row (read-before-write).
module line_buffer_ram
    import conv_window_stream_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH,
    parameter int BANKS = DEF_K - 1,
    parameter int PIX_W = DEF_DATA_W,
    parameter int AW    = clog2_safe(DEF_WIDTH),
    parameter int BW    = clog2_safe(DEF_K - 1)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [BW-1:0]    wr_bank,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata [BANKS]
);

    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
        logic [PIX_W-1:0] mem [DEPTH];

        // Only the bank holding the oldest row takes the incoming pixel.
        always_ff @(posedge clk) begin
            if (we && (wr_bank == BW'(gi))) begin
                mem[addr] <= wdata;
            end
        end

        assign rdata[gi] = mem[addr];
    end

endmodule

// File: rtl/conv_window_stream.sv
// Streaming KxK window generator with stride, valid/ready backpressure,
// start-of-frame resync and end-of-frame marking.
module conv_window_stream
    import conv_window_stream_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int K      = DEF_K,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH     = DEF_CH,
    parameter int STRIDE = DEF_STRIDE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH*DATA_W-1:0]       in_data,
    input  logic                       in_sof,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [K*K*CH*DATA_W-1:0]   out_window,
    output logic                       out_last
);

    localparam int PIX_W = CH * DATA_W;
    localparam int BANKS = K - 1;
    localparam int NX    = (WIDTH - K) / STRIDE + 1;
    localparam int NY    = (HEIGHT - K) / STRIDE + 1;
    localparam int XL    = K - 1 + STRIDE * (NX - 1);
    localparam int YL    = K - 1 + STRIDE * (NY - 1);
    localparam int XW    = clog2_safe(WIDTH);
    localparam int YW    = clog2_safe(HEIGHT);
    localparam int PW    = clog2_safe(STRIDE);
    localparam int BW    = clog2_safe(BANKS);

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;
    logic [PW-1:0] xph_q, xph_d, xph_cur;
    logic [PW-1:0] yph_q, yph_d, yph_cur;
    logic [BW-1:0] row_ptr_q, row_ptr_d;

    logic [PIX_W-1:0] win_q [K][K];
    logic [PIX_W-1:0] win_d [K][K];
    logic [PIX_W-1:0] new_col [K];
    logic [PIX_W-1:0] lb_rows [BANKS];
    logic [K*K*PIX_W-1:0] win_flat_d;
    logic [K*K*PIX_W-1:0] out_window_q;
    logic out_valid_q, out_last_q;

    logic accept, emit, is_last, row_end, frame_end;

    assign in_ready   = !rst && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_last   = out_last_q;

    // A start-of-frame pixel is treated as position (0,0) with zero phase.
    assign x_cur   = in_sof ? '0 : x_q;
    assign y_cur   = in_sof ? '0 : y_q;
    assign xph_cur = in_sof ? '0 : xph_q;
    assign yph_cur = in_sof ? '0 : yph_q;

    assign row_end   = (x_cur == XW'(WIDTH - 1));
    assign frame_end = row_end && (y_cur == YW'(HEIGHT - 1));
    assign emit      = (x_cur >= XW'(K - 1)) && (y_cur >= YW'(K - 1)) &&
                       (xph_cur == '0) && (yph_cur == '0);
    assign is_last   = (x_cur == XW'(XL)) && (y_cur == YW'(YL));

    line_buffer_ram #(
        .DEPTH (WIDTH),
        .BANKS (BANKS),
        .PIX_W (PIX_W),
        .AW    (XW),
        .BW    (BW)
    ) u_line_buffer (
        .clk     (clk),
        .we      (accept),
        .wr_bank (row_ptr_q),
        .addr    (x_cur),
        .wdata   (in_data),
        .rdata   (lb_rows)
    );

    // Rotate banks so the new column lists rows oldest first.
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_col
        logic [BW:0] sum;
        logic [BW:0] bank_sel;
        assign sum      = {1'b0, row_ptr_q} + (BW+1)'(gi);
        assign bank_sel = (sum >= (BW+1)'(BANKS)) ? sum - (BW+1)'(BANKS) : sum;
        assign new_col[gi] = lb_rows[bank_sel[BW-1:0]];
    end
    assign new_col[K-1] = in_data;

    // Next window: shift left by one column, append the fresh column on the right.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c + 1];
            end
            win_d[r][K-1] = new_col[r];
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_pack_r
        for (genvar gj = 0; gj < K; gj++) begin : g_pack_c
            assign win_flat_d[(gi*K + gj)*PIX_W +: PIX_W] = win_d[gi][gj];
        end
    end

    // Position, stride-phase and row-pointer advance for each accepted pixel.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        xph_d     = xph_q;
        yph_d     = yph_q;
        row_ptr_d = row_ptr_q;
        if (accept) begin
            if (row_end) begin
                x_d       = '0;
                xph_d     = '0;
                row_ptr_d = (row_ptr_q == BW'(BANKS - 1)) ? '0 : row_ptr_q + 1'b1;
                if (frame_end) begin
                    y_d   = '0;
                    yph_d = '0;
                end else begin
                    y_d = y_cur + 1'b1;
                    if (y_cur < YW'(K - 1) || yph_cur == PW'(STRIDE - 1)) begin
                        yph_d = '0;
                    end else begin
                        yph_d = yph_cur + 1'b1;
                    end
                end
            end else begin
                x_d   = x_cur + 1'b1;
                y_d   = y_cur;
                yph_d = yph_cur;
                if (x_cur < XW'(K - 1) || xph_cur == PW'(STRIDE - 1)) begin
                    xph_d = '0;
                end else begin
                    xph_d = xph_cur + 1'b1;
                end
            end
        end
    end

    // Counter and output-stage registers; output holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            xph_q        <= '0;
            yph_q        <= '0;
            row_ptr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_window_q <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            xph_q     <= xph_d;
            yph_q     <= yph_d;
            row_ptr_q <= row_ptr_d;
            if (accept) begin
                out_valid_q <= emit;
                out_last_q  <= emit && is_last;
                if (emit) begin
                    out_window_q <= win_flat_d;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Window shift register needs no reset: no emit happens before it is refilled.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_d;
        end
    end

endmodule

// File: tb/tb_conv_window_stream.sv
// Bench for conv_window_stream: three geometries driven from shared stimulus,
// expected windows computed from whole-frame images.
module tb_conv_window_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic        out_ready;
    logic [15:0] in_data;

    logic        in_ready_a, out_valid_a, out_last_a;
    logic [71:0] out_window_a;
    logic        in_ready_b, out_valid_b, out_last_b;
    logic [71:0] out_window_b;
    logic        in_ready_c, out_valid_c, out_last_c;
    logic [399:0] out_window_c;

    conv_window_stream #(.WIDTH(28), .HEIGHT(28), .K(3), .DATA_W(8), .CH(1), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data[7:0]), .in_sof(in_sof), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_window(out_window_a), .out_last(out_last_a));

    conv_window_stream #(.WIDTH(28), .HEIGHT(28), .K(3), .DATA_W(8), .CH(1), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data[7:0]), .in_sof(in_sof), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_window(out_window_b), .out_last(out_last_b));

    conv_window_stream #(.WIDTH(28), .HEIGHT(28), .K(5), .DATA_W(8), .CH(2), .STRIDE(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_window(out_window_c), .out_last(out_last_c));

    int sel;
    logic         m_in_ready, m_out_valid, m_out_last;
    logic [399:0] m_out_window;

    always_comb begin
        m_in_ready   = in_ready_a;
        m_out_valid  = out_valid_a;
        m_out_last   = out_last_a;
        m_out_window = 400'(out_window_a);
        if (sel == 1) begin
            m_in_ready   = in_ready_b;
            m_out_valid  = out_valid_b;
            m_out_last   = out_last_b;
            m_out_window = 400'(out_window_b);
        end else if (sel == 2) begin
            m_in_ready   = in_ready_c;
            m_out_valid  = out_valid_c;
            m_out_last   = out_last_c;
            m_out_window = out_window_c;
        end
    end

    // Model state: pending pixels and expected windows in emission order.
    logic [15:0]  pix_q [$];
    bit           sof_q [$];
    logic [399:0] expw_q [$];
    bit           expl_q [$];
    int           img [28][28][2];

    int checks;
    int errors;
    int valid_pct, ready_pct;
    int acc_cnt, nwin, first_acc;
    bit stall_prev;
    logic [399:0] prev_win, first_win;
    logic prev_last;

    task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [399:0] pack9(input int v [9]);
        logic [399:0] w;
        w = '0;
        for (int e = 0; e < 9; e++) w[e*8 +: 8] = 8'(v[e]);
        return w;
    endfunction

    // Full frame: image kind 0 = (28y+x)&255, 1 = inverted, 2 = random two-channel.
    task automatic push_frame(input int kind, input bit sof_first, input int k, input int s, input int ch);
        logic [399:0] w;
        int e;
        for (int y = 0; y < 28; y++) begin
            for (int x = 0; x < 28; x++) begin
                case (kind)
                    0: begin img[y][x][0] = (28*y + x) & 255;         img[y][x][1] = 0; end
                    1: begin img[y][x][0] = 255 - ((28*y + x) & 255); img[y][x][1] = 0; end
                    default: begin
                        img[y][x][0] = int'($urandom_range(255));
                        img[y][x][1] = int'($urandom_range(255));
                    end
                endcase
                pix_q.push_back({8'(img[y][x][1]), 8'(img[y][x][0])});
                sof_q.push_back(sof_first && (y == 0) && (x == 0));
            end
        end
        for (int y0 = 0; y0 + k <= 28; y0 += s) begin
            for (int x0 = 0; x0 + k <= 28; x0 += s) begin
                w = '0;
                for (int r = 0; r < k; r++) begin
                    for (int col = 0; col < k; col++) begin
                        e = r*k + col;
                        for (int c = 0; c < ch; c++) w[(e*ch + c)*8 +: 8] = 8'(img[y0+r][x0+col][c]);
                    end
                end
                expw_q.push_back(w);
                expl_q.push_back((y0 + s + k > 28) && (x0 + s + k > 28));
            end
        end
    endtask

    task automatic push_partial(input int n, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            pix_q.push_back(16'($urandom));
            sof_q.push_back(sof_first && (i == 0));
        end
    endtask

    task automatic do_reset(input int which);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        sel = which;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pix_q.delete();
        sof_q.delete();
        expw_q.delete();
        expl_q.delete();
        acc_cnt = 0;
        nwin = 0;
        first_acc = -1;
        stall_prev = 1'b0;
    endtask

    // One clock: drive inputs, then sample outputs mid low phase and check.
    task automatic step();
        @(negedge clk);
        in_valid = (pix_q.size() > 0) && ($urandom_range(99) < valid_pct);
        if (in_valid) begin
            in_data = pix_q[0];
            in_sof  = sof_q[0];
        end else begin
            in_data = 16'($urandom);
            in_sof  = 1'($urandom_range(1));
        end
        out_ready = ($urandom_range(99) < ready_pct);
        #1;
        if (stall_prev) begin
            checks++;
            if (!m_out_valid || m_out_window !== prev_win || m_out_last !== prev_last) begin
                errors++;
                $display("FAIL stall_hold actual=%0b/%0h required=1/%0h", m_out_valid, m_out_window, prev_win);
            end
        end
        if (m_out_valid && first_acc < 0) first_acc = acc_cnt;
        if (m_out_valid && out_ready) begin
            if (expw_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_window actual=%0h required=none", m_out_window);
            end else begin
                if (nwin == 0) first_win = m_out_window;
                chk($sformatf("window_%0d", nwin), m_out_window, expw_q[0]);
                chk($sformatf("last_%0d", nwin), 400'(m_out_last), 400'(expl_q[0]));
                void'(expw_q.pop_front());
                void'(expl_q.pop_front());
            end
            $display("win %0d last=%0b", nwin, m_out_last);
            nwin++;
        end
        stall_prev = m_out_valid && !out_ready;
        prev_win   = m_out_window;
        prev_last  = m_out_last;
        if (in_valid && m_in_ready) begin
            void'(pix_q.pop_front());
            void'(sof_q.pop_front());
            acc_cnt++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pix_q.size() > 0 || expw_q.size() > 0) && n < 20000) begin
            step();
            n++;
        end
        chk({name, "_drained"}, 400'(pix_q.size() + expw_q.size()), 400'(0));
        repeat (6) step();
    endtask

    initial begin
        int lst [9];
        checks = 0;
        errors = 0;
        sel = 0;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = '0;
        in_sof = 1'b0;
        out_ready = 1'b1;
        valid_pct = 100;
        ready_pct = 100;
        first_win = '0;

        // Reset behaviour with in_valid held high.
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", 400'(m_in_ready), 400'(0));
            chk("rst_out_valid", 400'(m_out_valid), 400'(0));
            chk("rst_out_window", m_out_window, 400'(0));
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 400'(m_in_ready), 400'(1));

        // Full-rate single frame, K=3 stride 1.
        do_reset(0);
        valid_pct = 100; ready_pct = 100;
        push_frame(0, 1'b0, 3, 1, 1);
        lst = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
        chk("model_a_count", 400'(expw_q.size()), 400'(676));
        chk("model_a_first", expw_q[0], pack9(lst));
        drain("a_full");
        chk("a_full_count", 400'(nwin), 400'(676));
        chk("a_full_first_latency", 400'(first_acc), 400'(59));
        chk("a_full_first_window", first_win, pack9(lst));

        // Same frame with random valid and ready.
        do_reset(0);
        valid_pct = 50; ready_pct = 50;
        push_frame(0, 1'b0, 3, 1, 1);
        drain("a_rand");
        chk("a_rand_count", 400'(nwin), 400'(676));
        chk("a_rand_first_latency", 400'(first_acc), 400'(59));

        // Stride 2.
        do_reset(1);
        valid_pct = 80; ready_pct = 70;
        push_frame(0, 1'b0, 3, 2, 1);
        chk("model_b_count", 400'(expw_q.size()), 400'(169));
        drain("b_stride2");
        chk("b_stride2_count", 400'(nwin), 400'(169));
        chk("b_stride2_first_latency", 400'(first_acc), 400'(59));

        // Back-to-back frames, second inverted.
        do_reset(0);
        valid_pct = 70; ready_pct = 50;
        push_frame(0, 1'b0, 3, 1, 1);
        push_frame(1, 1'b0, 3, 1, 1);
        lst = '{255, 254, 253, 227, 226, 225, 199, 198, 197};
        chk("model_frame2_first", expw_q[676], pack9(lst));
        drain("a_b2b");
        chk("a_b2b_count", 400'(nwin), 400'(1352));

        // K=5, two channels, in_sof resync at pixel index 100.
        do_reset(2);
        valid_pct = 70; ready_pct = 60;
        push_partial(100, 1'b1);
        push_frame(2, 1'b1, 5, 1, 2);
        chk("model_c_count", 400'(expw_q.size()), 400'(576));
        drain("c_sof");
        chk("c_sof_count", 400'(nwin), 400'(576));
        chk("c_sof_first_latency", 400'(first_acc), 400'(217));

        // Reset in the middle of a frame discards the partial frame.
        do_reset(0);
        valid_pct = 100; ready_pct = 100;
        push_partial(40, 1'b0);
        for (int i = 0; i < 200 && pix_q.size() > 0; i++) step();
        do_reset(0);
        push_frame(0, 1'b0, 3, 1, 1);
        drain("a_midrst");
        chk("a_midrst_count", 400'(nwin), 400'(676));
        chk("a_midrst_first_latency", 400'(first_acc), 400'(59));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
